// File: rtl/bright_pkg.sv
// Shared types, constants and the saturating-add helper for the brightness sequencer.
package bright_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} bright_state_t;

    localparam int BRIGHT_AW = 6;
    localparam int BRIGHT_DW = 8;
    localparam int PIX_MAX   = 2**BRIGHT_DW - 1;

    // Widened sum (-256..510) fits DW+2 bits, so the sign bit flags underflow and bit DW flags overflow.
    function automatic logic [BRIGHT_DW-1:0] sat_add(input logic [BRIGHT_DW-1:0] pixel,
                                                     input logic signed [BRIGHT_DW:0] offset);
        logic signed [BRIGHT_DW+1:0] sum;
        sum = $signed({2'b00, pixel}) + $signed({offset[BRIGHT_DW], offset});
        if (sum[BRIGHT_DW+1]) begin
            return '0;
        end else if (sum[BRIGHT_DW]) begin
            return '1;
        end else begin
            return sum[BRIGHT_DW-1:0];
        end
    endfunction

endpackage

// File: rtl/bright_sat_add.sv
// Combinational saturating pixel + signed offset, with clamp-low / clamp-high flags.
module bright_sat_add
    import bright_pkg::*;
#(
    parameter int DW = BRIGHT_DW
) (
    input  logic [DW-1:0]        pixel,
    input  logic signed [DW:0]   offset,
    output logic [DW-1:0]        result,
    output logic                 lo,
    output logic                 hi
);

    logic signed [DW+1:0] sum;

    assign sum = $signed({2'b00, pixel}) + $signed({offset[DW], offset});
    assign lo  = sum[DW+1];
    assign hi  = ~sum[DW+1] & sum[DW];

    generate
        if (DW == BRIGHT_DW) begin : g_pkg
            assign result = sat_add(pixel, offset);
        end else begin : g_generic
            logic [DW-1:0] clamp;
            assign clamp  = lo ? '0 : (hi ? '1 : sum[DW-1:0]);
            assign result = clamp;
        end
    endgenerate

endmodule

// File: rtl/bright_seq_ctrl.sv
// Frame sequencer: reads every source pixel, adds a latched signed offset with saturation,
// writes the result to the destination RAM. Optional clamp counters: BRIGHT_SAT_STATS_EN.
module bright_seq_ctrl
    import bright_pkg::*;
#(
    parameter int AW     = BRIGHT_AW,
    parameter int DW     = BRIGHT_DW,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 abort,
    input  logic signed [DW:0]   offset,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic [DW-1:0]        rd_data,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [DW-1:0]        wr_data
`ifdef BRIGHT_SAT_STATS_EN
    ,
    output logic [AW:0]          sat_lo_cnt,
    output logic [AW:0]          sat_hi_cnt
`endif
);

    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    bright_state_t        state_reg, state_next;
    logic [AW-1:0]        addr_reg, addr_next;
    logic signed [DW:0]   offset_reg;
    logic                 vld_pipe_reg [RD_LAT];
    logic [AW-1:0]        addr_pipe_reg [RD_LAT];
    logic                 wr_en_reg;
    logic [AW-1:0]        wr_addr_reg;
    logic [DW-1:0]        wr_data_reg;

    logic                 start_ok;
    logic                 abort_hit;
    logic                 last_addr;
    logic                 last_write;
    logic                 pix_vld;
    logic [DW-1:0]        sat_result;
    logic                 sat_lo;
    logic                 sat_hi;

    assign start_ok   = (state_reg == IDLE) && start && !abort;
    assign abort_hit  = abort && ((state_reg == ISSUE) || (state_reg == DRAIN));
    assign last_addr  = (addr_reg == {AW{1'b1}});
    assign last_write = wr_en_reg && (wr_addr_reg == {AW{1'b1}});
    assign pix_vld    = vld_pipe_reg[RD_LAT-1] && !abort_hit;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            offset_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            if (start_ok) begin
                offset_reg <= offset;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        rd_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    state_next = ISSUE;
                    addr_next  = '0;
                end
            end
            ISSUE: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (last_addr) begin
                    state_next = DRAIN;
                end else begin
                    addr_next = addr_reg + ADDR_ONE;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (last_write) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_addr = addr_reg;

    // Stage RD_LAT-1 lines up with the cycle its pixel appears on rd_data.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (!resetn) begin
                        vld_pipe_reg[gi]  <= 1'b0;
                        addr_pipe_reg[gi] <= '0;
                    end else begin
                        vld_pipe_reg[gi]  <= rd_en && !abort_hit;
                        addr_pipe_reg[gi] <= addr_reg;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (!resetn) begin
                        vld_pipe_reg[gi]  <= 1'b0;
                        addr_pipe_reg[gi] <= '0;
                    end else begin
                        vld_pipe_reg[gi]  <= vld_pipe_reg[gi-1] && !abort_hit;
                        addr_pipe_reg[gi] <= addr_pipe_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    bright_sat_add #(
        .DW     (DW)
    ) u_sat_add (
        .pixel  (rd_data),
        .offset (offset_reg),
        .result (sat_result),
        .lo     (sat_lo),
        .hi     (sat_hi)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg <= pix_vld;
            if (pix_vld) begin
                wr_addr_reg <= addr_pipe_reg[RD_LAT-1];
                wr_data_reg <= sat_result;
            end
        end
    end

    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;

`ifdef BRIGHT_SAT_STATS_EN
    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] sat_lo_cnt_reg;
    logic [AW:0] sat_hi_cnt_reg;

    // Counted as the pixel enters the write stage, so aborted pixels are never counted.
    always_ff @(posedge clk) begin
        if (!resetn || start_ok) begin
            sat_lo_cnt_reg <= '0;
            sat_hi_cnt_reg <= '0;
        end else if (pix_vld) begin
            if (sat_lo) begin
                sat_lo_cnt_reg <= sat_lo_cnt_reg + CNT_ONE;
            end
            if (sat_hi) begin
                sat_hi_cnt_reg <= sat_hi_cnt_reg + CNT_ONE;
            end
        end
    end

    assign sat_lo_cnt = sat_lo_cnt_reg;
    assign sat_hi_cnt = sat_hi_cnt_reg;
`else
    logic unused_sat_flags;
    assign unused_sat_flags = sat_lo ^ sat_hi;
`endif

endmodule

// File: tb/tb_bright_seq_ctrl.sv
// Directed, table-driven bench for bright_seq_ctrl (source RAM ramp src[i]=i*4).
module tb_bright_seq_ctrl;

    localparam int AW     = 6;
    localparam int DW     = 8;
    localparam int RD_LAT = 1;
    localparam int NPIX   = 64;

    logic              clk;
    logic              resetn;
    logic              start;
    logic              abort;
    logic signed [8:0] offset;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [5:0]        rd_addr;
    logic [7:0]        rd_data;
    logic              wr_en;
    logic [5:0]        wr_addr;
    logic [7:0]        wr_data;
`ifdef BRIGHT_SAT_STATS_EN
    logic [6:0]        sat_lo_cnt;
    logic [6:0]        sat_hi_cnt;
`endif

    bright_seq_ctrl #(
        .AW      (AW),
        .DW      (DW),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .abort   (abort),
        .offset  (offset),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
`ifdef BRIGHT_SAT_STATS_EN
        ,
        .sat_lo_cnt (sat_lo_cnt),
        .sat_hi_cnt (sat_hi_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source RAM with RD_LAT registered read stages.
    logic [7:0] src_mem [NPIX];
    logic [7:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= src_mem[rd_addr];
        for (int k = 1; k < RD_LAT; k++) begin
            rd_pipe[k] <= rd_pipe[k-1];
        end
    end
    assign rd_data = rd_pipe[RD_LAT-1];

    typedef struct {
        logic signed [8:0] off;
        int                poke;
        int                chk_idx;
        logic [7:0]        chk_val;
        int                exp_lo;
        int                exp_hi;
    } frame_vec_t;

    frame_vec_t vecs [8];
    logic [7:0] dst [NPIX];
    int checks, errors;
    int rel, wr_cnt, done_cnt, done_at, first_wr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Independent reference: integer sum then clamp.
    function automatic logic [7:0] model(input int px, input int off);
        int s;
        s = px + off;
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return s[7:0];
    endfunction

    task automatic tick();
        @(negedge clk);
        rel++;
        if (wr_en) begin
            dst[wr_addr] = wr_data;
            wr_cnt++;
            if (first_wr < 0) first_wr = rel;
        end
        if (done) begin
            done_cnt++;
            done_at = rel;
        end
    endtask

    task automatic begin_frame(input logic signed [8:0] off);
        for (int i = 0; i < NPIX; i++) dst[i] = 8'hA5;
        offset   = off;
        start    = 1'b1;
        rel      = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        done_at  = -1;
        first_wr = -1;
        tick();
        start = 1'b0;
        chk("busy_rise", busy, 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        offset = '0;
        for (int i = 0; i < NPIX; i++) src_mem[i] = 8'(i * 4);

        vecs[0] = '{off:  9'sd40,  poke: -1, chk_idx: 53, chk_val: 8'd252, exp_lo: 0,  exp_hi: 10};
        vecs[1] = '{off: -9'sd256, poke: -1, chk_idx: 63, chk_val: 8'd0,   exp_lo: 64, exp_hi: 0};
        vecs[2] = '{off:  9'sd255, poke: -1, chk_idx: 0,  chk_val: 8'd255, exp_lo: 0,  exp_hi: 63};
        vecs[3] = '{off:  9'sd0,   poke: -1, chk_idx: 37, chk_val: 8'd148, exp_lo: 0,  exp_hi: 0};
        vecs[4] = '{off: -9'sd10,  poke: -1, chk_idx: 3,  chk_val: 8'd2,   exp_lo: 3,  exp_hi: 0};
        vecs[5] = '{off:  9'sd100, poke: -1, chk_idx: 39, chk_val: 8'd255, exp_lo: 0,  exp_hi: 25};
        vecs[6] = '{off: -9'sd1,   poke: -1, chk_idx: 1,  chk_val: 8'd3,   exp_lo: 1,  exp_hi: 0};
        vecs[7] = '{off:  9'sd40,  poke: 20, chk_idx: 63, chk_val: 8'd255, exp_lo: 0,  exp_hi: 10};

        // Power-on reset state.
        repeat (3) tick();
        chk("reset_outputs", {busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data}, 0);
`ifdef BRIGHT_SAT_STATS_EN
        chk("reset_stats", {sat_lo_cnt, sat_hi_cnt}, 0);
`endif
        resetn = 1'b1;
        tick();

        // Reset held 3 clocks mid-frame discards everything in flight.
        begin
            int snap;
            begin_frame(9'sd40);
            while (rel < 20) tick();
            snap   = wr_cnt;
            resetn = 1'b0;
            repeat (3) tick();
            chk("midreset_outputs", {busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data}, 0);
            resetn = 1'b1;
            repeat (90) tick();
            chk("midreset_no_writes", wr_cnt, snap);
            chk("midreset_no_done", done_cnt, 0);
            chk("midreset_idle", busy, 0);
        end

        // Full frames from the vector table.
        for (int v = 0; v < 8; v++) begin
            int bad;
            begin_frame(vecs[v].off);
            for (int k = 0; k < 150 && done_cnt == 0; k++) begin
                start = (rel == vecs[v].poke);
                if (rel == vecs[v].poke) offset = -9'sd10;
                tick();
            end
            start = 1'b0;
            repeat (3) tick();
            chk("first_write_cycle", first_wr, 2 + RD_LAT);
            chk("done_cycle", done_at, 66 + RD_LAT);
            chk("done_pulses", done_cnt, 1);
            chk("write_count", wr_cnt, NPIX);
            chk("busy_after_done", busy, 0);
            chk("table_pixel", dst[vecs[v].chk_idx], vecs[v].chk_val);
            bad = 0;
            for (int i = 0; i < NPIX; i++) begin
                if (dst[i] !== model(i * 4, int'(vecs[v].off))) bad++;
            end
            chk("frame_pixels_bad", bad, 0);
`ifdef BRIGHT_SAT_STATS_EN
            chk("sat_lo_cnt", sat_lo_cnt, vecs[v].exp_lo);
            chk("sat_hi_cnt", sat_hi_cnt, vecs[v].exp_hi);
`endif
        end

        // Abort on the 10th read strobe.
        begin
            int k;
            begin_frame(9'sd0);
            k = 0;
            while (!(rd_en && rd_addr == 6'd9) && k < 30) begin
                tick();
                k++;
            end
            chk("abort_reached_addr9", rd_addr, 9);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort_busy_low", busy, 0);
            chk("abort_rd_en_low", rd_en, 0);
            chk("abort_wr_en_low", wr_en, 0);
            repeat (90) tick();
            chk("abort_write_count", wr_cnt, 9 - RD_LAT);
            chk("abort_no_done", done_cnt, 0);
            chk("abort_last_written", dst[8 - RD_LAT], model((8 - RD_LAT) * 4, 0));
            chk("abort_untouched", dst[9 - RD_LAT], 8'hA5);
        end

        // Abort in IDLE is a no-op; start together with abort is refused.
        abort = 1'b1;
        tick();
        chk("idle_abort_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_rd_en", rd_en, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
